// File: rtl/axi_test_pkg.sv
// Shared types and constants for the AXI register test master.
//   - state_t     : master FSM states
//   - AXI_*       : fixed AXI field encodings and response codes
//   - *_W         : ID/address/data/strobe widths
package axi_test_pkg;

  localparam int unsigned ID_W   = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 8;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_TIMEOUT = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RSP
  } state_t;

endpackage

// File: rtl/axi_hs_timeout.sv
// Handshake timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (state entry)
//   enable   : count this cycle (waiting on an AXI handshake)
//   expired  : count has reached TIMEOUT; holds there until cleared
module axi_hs_timeout #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TO_W'(1);
    end
  end

endmodule

// File: rtl/axi_reg_test_master.sv
// Single-outstanding AXI master turning register commands into single-beat
// AXI reads/writes, returning one response record per command.
//   ACLK/ARESET            : clock, synchronous active-high reset
//   cmd_*                  : command in (valid/ready, write, id, addr, wdata, wstrb)
//   rsp_*                  : response out (valid/ready, data, resp, timeout, id_err)
//   AR*/R*/AW*/W*/B*       : AXI master channels
module axi_reg_test_master
  import axi_test_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              rsp_id_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  state_t state, state_next;
  logic   aw_done, w_done;
  logic   aw_fin, w_fin;
  logic   busy, to_expired, to_abort;
  logic   unused_rlast;

  // Single-beat only; RLAST carries no information here.
  assign unused_rlast = RLAST;

  assign ARLEN   = '0;
  assign AWLEN   = '0;
  assign ARSIZE  = AXI_SIZE_4B;
  assign AWSIZE  = AXI_SIZE_4B;
  assign ARBURST = AXI_BURST_INCR;
  assign AWBURST = AXI_BURST_INCR;

  assign busy = (state == ST_RD_ADDR) || (state == ST_RD_DATA) ||
                (state == ST_WR_REQ)  || (state == ST_WR_RESP);

  axi_hs_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (ACLK),
    .rst     (ARESET),
    .clear   (state_next != state),
    .enable  (busy),
    .expired (to_expired)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A channel counts as finished if it handshook earlier or handshakes now.
  assign aw_fin = aw_done || (AWVALID && AWREADY);
  assign w_fin  = w_done  || (WVALID  && WREADY);

  // Handshakes are tested before expiry so a same-cycle handshake wins.
  always_comb begin
    state_next = state;
    to_abort   = 1'b0;
    case (state)
      ST_IDLE:    if (cmd_valid) state_next = cmd_write ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: begin
        if (ARREADY)         state_next = ST_RD_DATA;
        else if (to_expired) begin state_next = ST_RSP; to_abort = 1'b1; end
      end
      ST_RD_DATA: begin
        if (RVALID)          state_next = ST_RSP;
        else if (to_expired) begin state_next = ST_RSP; to_abort = 1'b1; end
      end
      ST_WR_REQ: begin
        if (aw_fin && w_fin) state_next = ST_WR_RESP;
        else if (to_expired) begin state_next = ST_RSP; to_abort = 1'b1; end
      end
      ST_WR_RESP: begin
        if (BVALID)          state_next = ST_RSP;
        else if (to_expired) begin state_next = ST_RSP; to_abort = 1'b1; end
      end
      ST_RSP:     if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) && !ARESET;
    ARVALID   = (state == ST_RD_ADDR);
    RREADY    = (state == ST_RD_DATA);
    AWVALID   = (state == ST_WR_REQ) && !aw_done;
    WVALID    = (state == ST_WR_REQ) && !w_done;
    BREADY    = (state == ST_WR_RESP);
    rsp_valid = (state == ST_RSP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ARID        <= '0;
      ARADDR      <= '0;
      AWID        <= '0;
      AWADDR      <= '0;
      WDATA       <= '0;
      WSTRB       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      rsp_id_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              AWID   <= cmd_id;
              AWADDR <= cmd_addr;
              WDATA  <= cmd_wdata;
              WSTRB  <= cmd_wstrb;
            end else begin
              ARID   <= cmd_id;
              ARADDR <= cmd_addr;
            end
          end
        end
        ST_WR_REQ: begin
          if (AWVALID && AWREADY) aw_done <= 1'b1;
          if (WVALID && WREADY)   w_done  <= 1'b1;
        end
        ST_RD_DATA: begin
          if (RVALID) begin
            rsp_data    <= RDATA;
            rsp_resp    <= RRESP;
            rsp_timeout <= 1'b0;
            rsp_id_err  <= (RID != ARID);
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            rsp_data    <= '0;
            rsp_resp    <= BRESP;
            rsp_timeout <= 1'b0;
            rsp_id_err  <= (BID != AWID);
          end
        end
        default: ;
      endcase
      if (to_abort) begin
        rsp_data    <= '0;
        rsp_resp    <= AXI_RESP_TIMEOUT;
        rsp_timeout <= 1'b1;
        rsp_id_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_test_master.sv
module tb_axi_reg_test_master;
  import axi_test_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_id;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, rsp_id_err;
  logic [15:0] ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [7:0]  WSTRB;

  always #5 ACLK = ~ACLK;

  axi_reg_test_master #(.TIMEOUT(16), .TO_W(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .rsp_id_err(rsp_id_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // ---------------- slave model (register map 0x0 data, 0x4 ctrl, 0x8 seed, 0xC count)
  int unsigned ar_lat = 0, aw_lat = 0, w_lat = 0;
  int unsigned ar_wait, aw_wait, w_wait;
  int unsigned aw_hs_cnt, w_hs_cnt;
  logic        ar_en = 1'b1, r_en = 1'b1;
  logic [15:0] bid_xor = '0;
  logic [31:0] ctrl_r, seed_r, rd0_cnt;
  logic        r_pend, got_aw, got_w;
  logic [31:0] s_awaddr, s_wdata;
  logic [15:0] s_awid;
  logic [7:0]  s_wstrb;

  assign ARREADY = ARVALID && ar_en && (ar_wait >= ar_lat);
  assign AWREADY = AWVALID && (aw_wait >= aw_lat);
  assign WREADY  = WVALID && (w_wait >= w_lat);
  assign RLAST   = 1'b1;

  always @(posedge ACLK) begin
    if (ARESET) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
      aw_hs_cnt <= 0; w_hs_cnt <= 0;
      ctrl_r <= '0; seed_r <= '0; rd0_cnt <= '0;
      r_pend <= 1'b0; RVALID <= 1'b0; RDATA <= '0; RRESP <= '0; RID <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; BVALID <= 1'b0; BRESP <= '0; BID <= '0;
      s_awaddr <= '0; s_wdata <= '0; s_awid <= '0; s_wstrb <= '0;
    end else begin
      ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      if (ARVALID && ARREADY) begin
        r_pend <= 1'b1;
        RID    <= ARID;
        RRESP  <= AXI_RESP_OKAY;
        case (ARADDR)
          32'h000: begin RDATA <= 32'hA000_0000 | rd0_cnt; rd0_cnt <= rd0_cnt + 1; end
          32'h004: RDATA <= ctrl_r;
          32'h008: RDATA <= seed_r;
          32'h00C: RDATA <= rd0_cnt;
          default: begin RDATA <= 32'hDEAD_BEEF; RRESP <= AXI_RESP_SLVERR; end
        endcase
      end
      if (RVALID && RREADY) begin
        RVALID <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        RVALID <= r_pend && r_en;
      end
      if (AWVALID && AWREADY) begin
        s_awaddr <= AWADDR; s_awid <= AWID; got_aw <= 1'b1; aw_hs_cnt <= aw_hs_cnt + 1;
      end
      if (WVALID && WREADY) begin
        s_wdata <= WDATA; s_wstrb <= WSTRB; got_w <= 1'b1; w_hs_cnt <= w_hs_cnt + 1;
      end
      if (got_aw && got_w && !BVALID) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        BVALID <= 1'b1; BID <= s_awid ^ bid_xor; BRESP <= AXI_RESP_OKAY;
        case (s_awaddr)
          32'h004: for (int i = 0; i < 4; i++) if (s_wstrb[i]) ctrl_r[8*i +: 8] <= s_wdata[8*i +: 8];
          32'h008: for (int i = 0; i < 4; i++) if (s_wstrb[i]) seed_r[8*i +: 8] <= s_wdata[8*i +: 8];
          default: BRESP <= AXI_RESP_SLVERR;
        endcase
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
    end
  end

  // ---------------- scoreboard and checking
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        to;
    logic        id_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic t, input logic ie);
    exp_t e;
    e.data = d; e.resp = r; e.to = t; e.id_err = ie;
    sb.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [15:0] id, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [7:0] ws);
    int unsigned n = 0;
    while (!cmd_ready && n < 64) begin @(negedge ACLK); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
    cmd_wdata = wd; cmd_wstrb = ws;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned hold);
    int unsigned n = 0;
    exp_t e;
    e = '0;
    while (!rsp_valid && n < 64) begin @(negedge ACLK); n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    if (sb.size() > 0) e = sb.pop_front();
    else chk("sb_pop", sb.size(), 1);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_resp", rsp_resp, e.resp);
    chk("rsp_timeout", rsp_timeout, e.to);
    chk("rsp_id_err", rsp_id_err, e.id_err);
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge ACLK);
      chk("hold_stable", {rsp_valid, cmd_ready, rsp_data, rsp_resp, rsp_timeout, rsp_id_err},
          {1'b1, 1'b0, e.data, e.resp, e.to, e.id_err});
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    chk("rsp_done_cmd_ready", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic rd_chk(input logic [15:0] id, input logic [31:0] addr,
                        input logic [31:0] ed, input logic [1:0] er, input int unsigned lat);
    int unsigned hi = 0, n = 0;
    ar_lat = lat;
    push_exp(ed, er, 1'b0, 1'b0);
    issue(1'b0, id, addr, '0, '0);
    while (n < 64) begin
      if (ARVALID) hi++;
      if (ARVALID && ARREADY) break;
      @(negedge ACLK); n++;
    end
    @(negedge ACLK);
    chk("arvalid_drop", ARVALID, 0);
    chk("arvalid_cycles", hi, lat + 1);
    wait_rsp(0);
  endtask

  initial begin
    int unsigned n;
    logic        last_av;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);

    // reset state
    chk("rst_handshakes", {cmd_ready, ARVALID, RREADY, AWVALID, WVALID, BREADY, rsp_valid}, 0);
    chk("rst_fields", {rsp_data, rsp_resp, rsp_timeout, rsp_id_err, ARADDR, AWADDR}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("cmd_ready_after_rst", cmd_ready, 1);
    chk("fixed_fields", {ARLEN, ARSIZE, ARBURST, AWLEN, AWSIZE, AWBURST},
        {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01});

    // write 0x008, AW delayed two cycles, W immediate
    aw_lat = 2; w_lat = 0;
    push_exp(32'h0, AXI_RESP_OKAY, 1'b0, 1'b0);
    issue(1'b1, 16'h00A5, 32'h008, 32'h1234_5678, 8'h0F);
    chk("wr_entry_valids", {AWVALID, WVALID}, 2'b11);
    chk("wr_fields", {AWID, AWADDR, WDATA, WSTRB}, {16'h00A5, 32'h008, 32'h1234_5678, 8'h0F});
    @(negedge ACLK);
    chk("w_drop_before_aw", {AWVALID, WVALID}, 2'b10);
    wait_rsp(0);
    chk("aw_hs_count", aw_hs_cnt, 1);
    chk("w_hs_count", w_hs_cnt, 1);
    aw_lat = 0;

    rd_chk(16'h00A5, 32'h008, 32'h1234_5678, AXI_RESP_OKAY, 1);
    rd_chk(16'h0007, 32'h0FC, 32'hDEAD_BEEF, AXI_RESP_SLVERR, 0);
    for (int unsigned i = 0; i < 4; i++)
      rd_chk(16'h0010, 32'h000, 32'hA000_0000 | i, AXI_RESP_OKAY, i);
    rd_chk(16'h0011, 32'h00C, 32'h0000_0004, AXI_RESP_OKAY, 0);

    // ARREADY stuck low: abort 17 cycles after accept
    ar_en = 1'b0;
    push_exp(32'h0, AXI_RESP_TIMEOUT, 1'b1, 1'b0);
    issue(1'b0, 16'h0020, 32'h004, '0, '0);
    n = 0; last_av = 1'b0;
    while (!rsp_valid && n < 40) begin last_av = ARVALID; @(negedge ACLK); n++; end
    chk("to_latency", n, 17);
    chk("to_arvalid_before", last_av, 1);
    chk("to_axi_idle", {ARVALID, RREADY}, 2'b00);
    wait_rsp(0);
    ar_en = 1'b1;

    // BID mismatch, response held for 5 cycles
    bid_xor = 16'h0003;
    push_exp(32'h0, AXI_RESP_OKAY, 1'b0, 1'b1);
    issue(1'b1, 16'h0002, 32'h004, 32'h0000_0001, 8'h0F);
    wait_rsp(5);
    bid_xor = '0;

    // reset while waiting in the read-data phase
    r_en = 1'b0;
    issue(1'b0, 16'h0030, 32'h004, '0, '0);
    n = 0;
    while (!RREADY && n < 10) begin @(negedge ACLK); n++; end
    chk("in_rd_data", RREADY, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_handshakes", {cmd_ready, ARVALID, RREADY, AWVALID, WVALID, BREADY, rsp_valid}, 0);
    ARESET = 1'b0; r_en = 1'b1;
    @(negedge ACLK);
    chk("midrst_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    repeat (4) @(negedge ACLK);
    chk("midrst_no_rsp", {rsp_valid, RREADY}, 2'b00);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/axi_reg_test_master.md
Name: axi_reg_test_master

Overview:
- Single-outstanding AXI master that turns simple register commands (read/write, address, data, strobe) into AXI single-beat transactions.
- Sits directly upstream of axi_rng_slave and drives its AR/R/AW/W/B channels.
- Returns one response record per command, carrying data, RESP, ID check and timeout status.
- Used by the register-test sequencer to program control/seed registers and sample RNG data.

Parameters:
- TIMEOUT, 256: max cycles waited on any single AXI handshake before abort; must be >= 2.
- TO_W, 9: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master idle, command accepted this cycle if cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_id  in  16  AXI ID to use.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  8  write strobe.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  RDATA for reads, 0 for writes.
- rsp_resp  out  2  RRESP/BRESP, or 2'b11 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- rsp_id_err  out  1  returned RID/BID != cmd_id.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  16/32/4/3/2  read address.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- RID/RDATA/RRESP/RLAST  in  16/32/2/1  read data.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  16/32/4/3/2  write address.
- AWVALID  out  1  write address valid.
- AWREADY  in  1  write address ready.
- WDATA/WSTRB  out  32/8  write data.
- WVALID  out  1  write data valid.
- WREADY  in  1  write data ready.
- BID/BRESP  in  16/2  write response.
- BVALID  in  1  write response valid.
- BREADY  out  1  write response ready.

Behaviour:
- Clocking and reset: one clock ACLK; ARESET synchronous, active-high. All state updates on the ACLK rising edge.
- Reset values:
  - all VALID/READY outputs 0; cmd_ready 0 during reset, 1 on the first cycle after release.
  - all address/ID/data outputs and rsp_* outputs 0; state IDLE; timeout counter 0.
- Fixed AXI fields: ARLEN=AWLEN=0; ARSIZE=AWSIZE=3'b010; ARBURST=AWBURST=2'b01.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_id/addr/wdata/wstrb into AR* or AW*/W* registers and go to RD_ADDR or WR_REQ.
  - The VALID output rises on the next cycle (1-cycle command-to-VALID latency).
- RD_ADDR:
  - ARVALID=1 until the ARVALID&&ARREADY cycle.
  - ARVALID drops the cycle after the handshake; go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID: capture RDATA, RRESP and id_err=(RID!=cmd_id); go to RSP.
  - RLAST is ignored (single beat).
- WR_REQ:
  - AWVALID and WVALID both asserted on entry.
  - Each is deasserted independently after its own handshake; either order or the same cycle is legal.
  - Go to WR_RESP only when both have completed.
- WR_RESP:
  - BREADY=1.
  - On BVALID: capture BRESP and id_err; rsp_data=0; go to RSP.
- RSP:
  - rsp_valid=1 with all rsp_* fields stable until rsp_ready; then go to IDLE.
  - cmd_ready stays 0 until IDLE.
- Timeout:
  - Counter clears on every state entry and increments each cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP.
  - When it reaches TIMEOUT: drop all AXI VALID/READY; set rsp_resp=2'b11, rsp_timeout=1, rsp_data=0, rsp_id_err=0; go to RSP.
  - A handshake in the same cycle as the timeout wins; the timeout is ignored.
  - Late slave responses after a timeout are not consumed (RREADY/BREADY stay 0).
- Reset mid-operation: returns to IDLE in one cycle, drops VALIDs immediately and discards any pending response.
- Never more than one transaction outstanding.

Decomposition:
- Package axi_test_pkg:
  - state enum;
  - AXI_RESP_OKAY=2'b00, SLVERR=2'b10, TIMEOUT code 2'b11;
  - SIZE_4B=3'b010, BURST_INCR=2'b01;
  - ID/ADDR/DATA/STRB widths 16/32/32/8.
- One sub-module, axi_hs_timeout:
  - counter with clear/enable;
  - expired output driven by TIMEOUT.

Test Plan:
- Write to axi_rng_slave: cmd_write=1, addr 0x008, wdata 0x12345678, wstrb 0x0F, id 0x00A5 -> one AW and one W handshake; then a read of 0x008 -> rsp_data 0x12345678, rsp_resp 00, rsp_id_err 0.
- Read of unmapped address 0x0FC -> rsp_data 0xDEADBEEF, rsp_resp 2'b10, rsp_timeout 0.
- Four reads of 0x000, then a read of 0x00C -> rsp_data 0x00000004; ARVALID is high exactly until each ARREADY cycle.
- Stub slave ties ARREADY=0, TIMEOUT=16 -> ARVALID drops and rsp_valid rises 17 cycles after cmd accept, with rsp_resp 11 and rsp_timeout 1.
- Stub returns BID=0x0001 for cmd_id 0x0002; rsp_ready held low 5 cycles -> rsp_id_err 1, fields stable for all 5 cycles, cmd_ready 0 until after rsp_ready.
- Assert ARESET while in RD_DATA -> next cycle: all VALID/READY 0, cmd_ready 1 after release, no rsp_valid.
